// File: rtl/iterative_alu.sv
// Multi-cycle 32-bit ALU with valid/ready handshakes on request and result.
// Define ALU_BARREL_SHIFT_EN to finish shifts in one cycle instead of one bit per cycle.
module iterative_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state;
  logic [31:0] result_q;
  logic [31:0] work_q;
  logic [4:0]  cnt_q;
  logic [3:0]  ctrl_q;

  function automatic logic [31:0] alu_eval(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (c)
      4'b0000:          r = a & b;
      4'b0001:          r = a | b;
      4'b0110:          r = a - b;
      4'b1010:          r = a ^ b;
      4'b1000:          r = a << b[4:0];
      4'b1001:          r = a >> b[4:0];
      4'b0011:          r = $unsigned($signed(a) >>> b[4:0]);
      4'b0111, 4'b1011: r = {31'd0, $signed(a) < $signed(b)};
      4'b1111, 4'b1101: r = {31'd0, a < b};
      4'b1110:          r = {31'd0, a != b};
      default:          r = a + b;
    endcase
    return r;
  endfunction

  function automatic logic is_shift(input logic [3:0] c);
    return (c == 4'b1000) || (c == 4'b1001) || (c == 4'b0011);
  endfunction

  function automatic logic [31:0] shift1(input logic [3:0] c, input logic [31:0] w);
    logic [31:0] r;
    case (c)
      4'b1000: r = {w[30:0], 1'b0};
      4'b1001: r = {1'b0, w[31:1]};
      default: r = {w[31], w[31:1]};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      result_q <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      ctrl_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_BARREL_SHIFT_EN
            result_q <= alu_eval(alu_ctrl, op_a, op_b);
            state    <= DONE;
`else
            if (is_shift(alu_ctrl) && (op_b[4:0] != 5'd0)) begin
              work_q <= op_a;
              cnt_q  <= op_b[4:0];
              ctrl_q <= alu_ctrl;
              state  <= SHIFT;
            end else begin
              result_q <= is_shift(alu_ctrl) ? op_a : alu_eval(alu_ctrl, op_a, op_b);
              state    <= DONE;
            end
`endif
          end
        end
        SHIFT: begin
          // The final shift step writes straight into result so DONE follows N shift cycles.
          work_q <= shift1(ctrl_q, work_q);
          cnt_q  <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            result_q <= shift1(ctrl_q, work_q);
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_iterative_alu.sv
// Directed and random checks of iterative_alu using an expected-result queue.
module tb_iterative_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  iterative_alu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    int unsigned n;
    n = b[4:0];
    r = a;
    case (c)
      4'd0:        r = a & b;
      4'd1:        r = a | b;
      4'd6:        r = a + ~b + 32'd1;
      4'd10:       r = a ^ b;
      4'd8:        for (int unsigned i = 0; i < n; i++) r = {r[30:0], 1'b0};
      4'd9:        for (int unsigned i = 0; i < n; i++) r = {1'b0, r[31:1]};
      4'd3:        for (int unsigned i = 0; i < n; i++) r = {r[31], r[31:1]};
      4'd7, 4'd11: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd15, 4'd13: r = (a < b) ? 32'd1 : 32'd0;
      4'd14:       r = (a == b) ? 32'd0 : 32'd1;
      default:     r = a + b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if ((c == 4'd8 || c == 4'd9 || c == 4'd3) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // Issue one op, scramble the inputs after accept, then consume the result.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int lat;
    int busy_hi;
    logic [31:0] e;
    wait_ready();
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    exp_q.push_back(ref_alu(c, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = ~a; op_b = ~b; alu_ctrl = ~c;
    lat = 1; busy_hi = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_hi++;
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, exp_lat(c, b));
    check("in_ready_busy", busy_hi, 0);
    check("in_ready_done", {31'd0, in_ready}, 32'd0);
    e = exp_q.pop_front();
    check("result", result, e);
    check("zero", {31'd0, zero}, {31'd0, e == 32'd0});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_consume", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    logic [3:0] codes [13];
    logic [31:0] e;
    int vcnt;
    codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd10, 4'd8, 4'd9, 4'd3, 4'd7, 4'd11, 4'd15, 4'd13, 4'd14};

    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_out_ready_noeffect", {30'd0, in_ready, out_valid}, 32'd2);
    out_ready = 1'b0;

    run_op(4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_wrap_hold", result, 32'h8000_0000);
    check("add_wrap_zero", {31'd0, zero}, 32'd0);
    run_op(4'd6, 32'd5, 32'd5);
    check("sub_zero", {31'd0, zero}, 32'd1);
    run_op(4'd14, 32'd5, 32'd5);
    check("ne_equal", result, 32'd0);
    run_op(4'd14, 32'd5, 32'd6);
    check("ne_differ", result, 32'd1);
    run_op(4'd3, 32'h8000_0000, 32'd4);
    check("sra_const", result, 32'hF800_0000);
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1);
    check("slt_signed", result, 32'd1);
    run_op(4'd15, 32'hFFFF_FFFF, 32'd1);
    check("slt_unsigned", result, 32'd0);
    run_op(4'd11, 32'h8000_0000, 32'h7FFF_FFFF);
    run_op(4'd13, 32'd3, 32'd9);
    run_op(4'd8, 32'h1234_5678, 32'hFFFF_FFE0);
    check("shamt0", result, 32'h1234_5678);
    run_op(4'd9, 32'h8000_0000, 32'd31);
    run_op(4'd8, 32'h0000_0003, 32'd1);
    run_op(4'd4, 32'd3, 32'd4);
    check("default_add", result, 32'd7);
    run_op(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    run_op(4'd1, 32'hF0F0_F0F0, 32'h0F0F_0000);
    run_op(4'd10, 32'hAAAA_5555, 32'hFFFF_0000);
    for (int k = 0; k < 20; k++) begin
      run_op(codes[$urandom_range(12, 0)], $urandom, $urandom);
    end

    // Backpressure: result must hold while DONE waits and new requests are ignored.
    wait_ready();
    alu_ctrl = 4'd2; op_a = 32'h0000_1000; op_b = 32'h0000_0234; in_valid = 1'b1;
    exp_q.push_back(ref_alu(4'd2, 32'h0000_1000, 32'h0000_0234));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      op_a = 32'hDEAD_0000 + k;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", result, e);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    check("bp_result_end", result, 32'h0000_1234);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {30'd0, in_ready, out_valid}, 32'd2);
    check("bp_hold_after", result, 32'h0000_1234);

    // Reset in the middle of a long shift must drop the operation.
    wait_ready();
    alu_ctrl = 4'd8; op_a = 32'd1; op_b = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) vcnt++;
    end
    check("no_stale_result", vcnt, 0);
    check("post_rst_idle", {31'd0, in_ready}, 32'd1);
    check("scoreboard_empty", exp_q.size(), 0);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
